// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES constants, GF(2^8) helpers and the FSM encoding
//               used by the sequential MixColumns engine.
//               GF(2^8) arithmetic is modulo x^8+x^4+x^3+x+1 (0x11b).
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

  localparam int         AES_NCOLS   = 4;
  localparam int         AES_STATE_W = 128;
  localparam logic [7:0] AES_POLY    = 8'h1b;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mc_state_e;

  // Multiply by x, reducing by the field polynomial when bit 7 falls out.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul2(input logic [7:0] x);
    return xtime(x);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] x);
    return xtime(x) ^ x;
  endfunction

  // 9 = 8 ^ 1
  function automatic logic [7:0] gf_mul9(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ x;
  endfunction

  // 0b = 8 ^ 2 ^ 1
  function automatic logic [7:0] gf_mul11(input logic [7:0] x);
    logic [7:0] x2;
    x2 = xtime(x);
    return xtime(xtime(x2)) ^ x2 ^ x;
  endfunction

  // 0d = 8 ^ 4 ^ 1
  function automatic logic [7:0] gf_mul13(input logic [7:0] x);
    logic [7:0] x4;
    x4 = xtime(xtime(x));
    return xtime(x4) ^ x4 ^ x;
  endfunction

  // 0e = 8 ^ 4 ^ 2
  function automatic logic [7:0] gf_mul14(input logic [7:0] x);
    logic [7:0] x2;
    logic [7:0] x4;
    x2 = xtime(x);
    x4 = xtime(x2);
    return xtime(x4) ^ x4 ^ x2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mix_columns_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : mix_columns_seq_if
// Description : Valid/ready bundle between a producer of AES states and the
//               MixColumns engine.
//   in_valid/in_ready/state_in/inv_in : request side (producer -> engine)
//   out_valid/out_ready/state_out     : result side  (engine -> consumer)
//   busy                              : engine is transforming columns
//   master modport : producer/consumer view; slave modport : engine view
// Revision    : 1.0 - initial release
// ============================================================================
interface mix_columns_seq_if;
  import aes_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [AES_STATE_W-1:0] state_in;
  logic                   inv_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [AES_STATE_W-1:0] state_out;
  logic                   busy;

  modport master (
    output in_valid, state_in, inv_in, out_ready,
    input  in_ready, out_valid, state_out, busy
  );

  modport slave (
    input  in_valid, state_in, inv_in, out_ready,
    output in_ready, out_valid, state_out, busy
  );

endinterface
`default_nettype wire

// File: rtl/mix_column_word.sv
`default_nettype none
// ============================================================================
// Module      : mix_column_word
// Description : Combinational MixColumns / InvMixColumns on one 32-bit
//               column. Row 0 byte sits in bits [31:24], row 3 in [7:0].
//   col_in  : input column
//   inv     : 0 = forward matrix, 1 = inverse matrix
//   col_out : transformed column
// Revision    : 1.0 - initial release
// ============================================================================
module mix_column_word
  import aes_pkg::*;
(
  input  logic [31:0] col_in,
  input  logic        inv,
  output logic [31:0] col_out
);

  logic [7:0] a0;
  logic [7:0] a1;
  logic [7:0] a2;
  logic [7:0] a3;

  assign a0 = col_in[31:24];
  assign a1 = col_in[23:16];
  assign a2 = col_in[15:8];
  assign a3 = col_in[7:0];

  always_comb begin
    col_out = '0;
    if (inv) begin
      col_out = {gf_mul14(a0) ^ gf_mul11(a1) ^ gf_mul13(a2) ^ gf_mul9(a3),
                 gf_mul9(a0)  ^ gf_mul14(a1) ^ gf_mul11(a2) ^ gf_mul13(a3),
                 gf_mul13(a0) ^ gf_mul9(a1)  ^ gf_mul14(a2) ^ gf_mul11(a3),
                 gf_mul11(a0) ^ gf_mul13(a1) ^ gf_mul9(a2)  ^ gf_mul14(a3)};
    end else begin
      col_out = {gf_mul2(a0) ^ gf_mul3(a1) ^ a2 ^ a3,
                 a0 ^ gf_mul2(a1) ^ gf_mul3(a2) ^ a3,
                 a0 ^ a1 ^ gf_mul2(a2) ^ gf_mul3(a3),
                 gf_mul3(a0) ^ a1 ^ a2 ^ gf_mul2(a3)};
    end
  end

endmodule
`default_nettype wire

// File: rtl/mix_columns_seq.sv
`default_nettype none
// ============================================================================
// Module      : mix_columns_seq
// Description : Sequential, handshaked AES MixColumns / InvMixColumns engine.
//               Captures a 128-bit state, transforms COLS_PER_CYCLE columns
//               per clock and holds the result until the consumer takes it.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : valid/ready request + result bundle (slave side)
//   COLS_PER_CYCLE : 1, 2 or 4 columns per clock (latency 4, 2 or 1)
// Revision    : 1.0 - initial release
// ============================================================================
module mix_columns_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
)(
  input  logic                    clk,
  input  logic                    rst_n,
  mix_columns_seq_if.slave        bus
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4))
  begin : g_bad_cols_per_cycle
    $fatal(1, "mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // Counter step; for 4 columns per cycle it wraps to 0, which is harmless
  // because the single group always starts at column 0.
  localparam logic [1:0] CNT_STEP   = 2'(COLS_PER_CYCLE);
  localparam logic [2:0] CNT_STEP_W = 3'(COLS_PER_CYCLE);

  mc_state_e              state_q,  state_d;
  logic [1:0]             cnt_q,    cnt_d;
  logic [AES_STATE_W-1:0] data_q,   data_d;
  logic                   inv_q,    inv_d;
  logic [AES_STATE_W-1:0] result_q, result_d;
  // Keeps in_ready low while in reset and releases it on the first edge after.
  logic                   rdy_en_q;

  logic                   in_ready_w;
  logic [1:0]             col_idx_w [COLS_PER_CYCLE];
  logic [31:0]            col_in_w  [COLS_PER_CYCLE];
  logic [31:0]            col_out_w [COLS_PER_CYCLE];

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    localparam logic [1:0] COL_OFFS = 2'(g);

    assign col_idx_w[g] = cnt_q + COL_OFFS;
    assign col_in_w[g]  = data_q[{col_idx_w[g], 5'd0} +: 32];

    mix_column_word u_word (
      .col_in  (col_in_w[g]),
      .inv     (inv_q),
      .col_out (col_out_w[g])
    );
  end

  assign in_ready_w = rdy_en_q && (state_q == ST_IDLE);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    inv_d    = inv_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && in_ready_w) begin
          data_d  = bus.state_in;
          inv_d   = bus.inv_in;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
          result_d[{col_idx_w[g], 5'd0} +: 32] = col_out_w[g];
        end
        cnt_d = cnt_q + CNT_STEP;
        if (({1'b0, cnt_q} + CNT_STEP_W) == 3'd4) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      data_q   <= '0;
      inv_q    <= 1'b0;
      result_q <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      inv_q    <= inv_d;
      result_q <= result_d;
      rdy_en_q <= 1'b1;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q == ST_BUSY);
  assign bus.state_out = result_q;

endmodule
`default_nettype wire

// File: doc/mix_columns_seq.md
Name: mix_columns_seq

Overview:
- Sequential, handshaked AES MixColumns / InvMixColumns engine for the iterative AES round datapath.
- Accepts a 128-bit state plus a mode bit and processes COLS_PER_CYCLE columns per clock.
- Holds the result until the consumer accepts it.
- Generalises the combinational forward-only mixer: adds the inverse mode, a throughput/area trade-off parameter, and valid/ready flow control.

Parameters:
- COLS_PER_CYCLE, 1, columns transformed per clock; legal values 1, 2, 4. Any other value is a fatal elaboration error.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  state_in/inv_in valid
- in_ready  out  1  engine can accept a new state
- state_in  in  128  input state; column c = bits [c*32+:32]; row 0 byte = bits [c*32+24+:8], row 3 byte = bits [c*32+:8]
- inv_in  in  1  0 = MixColumns, 1 = InvMixColumns
- out_valid  out  1  state_out valid
- out_ready  in  1  consumer accepts state_out
- state_out  out  128  result, same byte layout as state_in
- busy  out  1  high while in the BUSY state

Behaviour:
- Reset values: in_ready=0 while rst_n is low, then 1 from the first clock edge after deassertion. out_valid=0, busy=0, state_out=0, column counter=0, FSM=IDLE.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture state_in and inv_in into internal registers, clear the counter, go to BUSY.
- BUSY:
  - in_ready=0.
  - Each cycle, transform columns counter..counter+COLS_PER_CYCLE-1 of the captured state and write them into the result register.
  - Counter advances by COLS_PER_CYCLE.
  - When the last group is written (counter+COLS_PER_CYCLE==4), go to DONE.
- DONE:
  - out_valid=1; state_out = result register, held stable while out_ready=0.
  - On out_ready: go to IDLE, out_valid=0 next cycle.
- Latency: accept at edge T; out_valid rises at edge T+4/COLS_PER_CYCLE, i.e. 4, 2 or 1 cycles.
- No same-cycle re-accept: in_ready stays 0 during DONE. Minimum issue interval is 4/COLS_PER_CYCLE+1 cycles, given out_ready=1.
- in_valid is ignored outside IDLE. state_in and inv_in may change freely after acceptance.
- out_ready is ignored when out_valid=0.
- state_out holds its last value after the handshake until the next result is written. Partial updates during BUSY are visible on state_out but qualified by out_valid=0.
- Forward matrix, per column (a0..a3 = rows 0..3): b0=2a0^3a1^a2^a3, b1=a0^2a1^3a2^a3, b2=a0^a1^2a2^3a3, b3=3a0^a1^a2^2a3.
- Inverse matrix rows: [0e 0b 0d 09], [09 0e 0b 0d], [0d 09 0e 0b], [0b 0d 09 0e].
- Arithmetic is GF(2^8) modulo 0x11b:
  - xtime(x) = (x<<1) ^ (x[7] ? 0x1b : 0), truncated to 8 bits.
  - Higher multiples are built from xtime chains plus XOR: 9=8^1, 0b=8^2^1, 0d=8^4^1, 0e=8^4^2.
- Reset mid-operation: abort immediately; all state returns to reset values; a captured state is discarded.

Decomposition:
- Package aes_pkg holds:
  - constants AES_NCOLS=4, AES_STATE_W=128, AES_POLY=8'h1b
  - functions xtime, gf_mul2, gf_mul3, gf_mul9, gf_mul11, gf_mul13, gf_mul14
  - typedef for the FSM encoding
- Sub-module mix_column_word: purely combinational, 32-bit column in, inv select, 32-bit column out. Instantiate COLS_PER_CYCLE copies. Column selection is a mux on the counter.
- The FSM, counter and registers stay in mix_columns_seq.

Test Plan:
1. COLS_PER_CYCLE=1, inv_in=0, state_in=128'hdb135345_f20a225c_01010101_c6c6c6c6, out_ready=1 -> out_valid exactly 4 cycles after acceptance; state_out=128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6; out_valid pulses for 1 cycle; in_ready returns the cycle after.
2. COLS_PER_CYCLE=4, inv_in=1, state_in=128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6 -> state_out=128'hdb135345_f20a225c_01010101_c6c6c6c6 after 1 cycle. Repeat with COLS_PER_CYCLE=2 -> latency 2.
3. Backpressure: forward, column d4d4d4d5 replicated in all four columns, out_ready=0 for 10 cycles -> out_valid stays 1, state_out stable at 128'hd5d5d7d6 replicated, in_ready=0 throughout; in_valid pulses with other data are ignored; releasing out_ready completes the handshake.
4. Reset mid-operation: accept state 128'h2d26314c replicated, drop rst_n on cycle 2 of BUSY -> out_valid=0, in_ready=0, state_out=0 immediately. After release, a fresh accept yields 128'h4d7ebdf8 replicated.
5. Back-to-back stream of 100 random states, random inv_in, random out_ready stalls, all three COLS_PER_CYCLE values -> every result matches the scoreboard reference model. InvMix(Mix(x))==x round-trip holds; no accept while in_ready=0; no dropped or duplicated outputs.
